// File: rtl/ofc_readout_pkg.sv
// Shared definitions for the event readout path: word tags, field widths,
// the readout FSM states and the stream word carried through the output FIFO.
package ofc_readout_pkg;

    localparam int WORD_W = 16;
    localparam int ES_W   = 11;
    localparam int L1A_W  = 14;

    localparam logic [1:0] HDR_TAG = 2'b10;
    localparam logic [7:0] TRL_TAG = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_RD,
        ST_HDR_CAP,
        ST_STREAM,
        ST_TRAILER
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } stream_word_t;

    function automatic logic [WORD_W-1:0] hdr_word(input logic [L1A_W-1:0] l1a);
        return {HDR_TAG, l1a};
    endfunction

    function automatic logic [WORD_W-1:0] size_word(input logic [ES_W-1:0] size);
        return {{(WORD_W-ES_W){1'b0}}, size};
    endfunction

    function automatic logic [WORD_W-1:0] trl_word(input logic [7:0] evt_lsb);
        return {TRL_TAG, evt_lsb};
    endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Two-entry output FIFO in front of the valid/ready stream. The head entry is
// a register, so the presented word stays stable while the sink stalls.
module out_skid_fifo
    import ofc_readout_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  stream_word_t push_word,
    input  logic         ready,
    output logic         valid,
    output logic         accept,
    output stream_word_t head,
    output logic [1:0]   count
);

    stream_word_t mem [2];
    logic         wr_idx;
    logic         rd_idx;

    assign valid  = (count != 2'd0);
    assign accept = valid && ready;
    assign head   = mem[rd_idx];

    // Storage, indices and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the two entries are reset because the head drives out_data, which must read zero after reset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_word;
                wr_idx      <= ~wr_idx;
            end
            if (accept) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + {1'b0, push} - {1'b0, accept};
        end
    end

endmodule

// File: rtl/mem_read_scheduler.sv
// Reads complete events out of the es/L1A/data RAMs and frames each one as
// header, size, payload, trailer on a valid/ready stream.
module mem_read_scheduler
    import ofc_readout_pkg::*;
#(
    parameter int DATA_AW = 16,
    parameter int EVT_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [EVT_AW-1:0]  es_wr_addr,
    output logic [EVT_AW-1:0]  es_rd_addr,
    input  logic [ES_W-1:0]    es_rd_data,
    output logic [EVT_AW-1:0]  L1A_rd_addr,
    input  logic [L1A_W-1:0]   L1A_rd_data,
    output logic [DATA_AW-1:0] data_rd_addr,
    input  logic [WORD_W-1:0]  data_rd_data,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic [EVT_AW-1:0]  evt_sent
);

    rd_state_t          state;
    rd_state_t          next_state;
    logic [EVT_AW-1:0]  rd_ptr;
    logic [DATA_AW-1:0] data_addr_q;
    logic [ES_W-1:0]    size_q;
    logic [ES_W-1:0]    issued_q;
    logic               hdr_pushed_q;
    logic               trl_pushed_q;
    logic               inflight_q;

    logic               hdr_push;
    logic               size_push;
    logic               data_push;
    logic               trl_push;
    logic               issue;
    stream_word_t       push_word;

    logic               fifo_accept;
    stream_word_t       fifo_head;
    logic [1:0]         fifo_count;
    logic [1:0]         occ_after;
    logic               can_push;
    logic               evt_avail;
    logic               reads_done;
    logic               trl_done;

    // The write side pre-increments, so the next unread event sits one past rd_ptr.
    assign es_rd_addr   = rd_ptr + EVT_AW'(1);
    assign L1A_rd_addr  = es_rd_addr;
    assign data_rd_addr = data_addr_q;
    assign busy         = (state != ST_IDLE);

    assign evt_avail  = (es_wr_addr != rd_ptr);
    assign reads_done = (issued_q == size_q);
    // Occupancy once this cycle's pop is taken into account; a returning read always fits.
    assign occ_after  = fifo_count - {1'b0, fifo_accept};
    assign can_push   = (fifo_count != 2'd2) || fifo_accept;
    assign trl_done   = (state == ST_TRAILER) && trl_pushed_q && fifo_accept && fifo_head.last;

    out_skid_fifo u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hdr_push | size_push | data_push | trl_push),
        .push_word (push_word),
        .ready     (out_ready),
        .valid     (out_valid),
        .accept    (fifo_accept),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_data = fifo_head.data;
    assign out_last = out_valid && fifo_head.last;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        next_state = state;
        unique case (state)
            ST_IDLE:    if (enable && evt_avail) next_state = ST_HDR_RD;
            ST_HDR_RD:  next_state = ST_HDR_CAP;
            ST_HDR_CAP: if (size_push) next_state = (size_q != '0) ? ST_STREAM : ST_TRAILER;
            ST_STREAM:  if (reads_done && !inflight_q) next_state = ST_TRAILER;
            ST_TRAILER: if (trl_done) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: which word enters the FIFO this cycle and whether a data read is issued.
    always_comb begin
        hdr_push  = 1'b0;
        size_push = 1'b0;
        data_push = 1'b0;
        trl_push  = 1'b0;
        issue     = 1'b0;
        push_word = '0;
        unique case (state)
            ST_HDR_CAP: begin
                if (!hdr_pushed_q) begin
                    hdr_push       = can_push;
                    push_word.data = hdr_word(L1A_rd_data);
                end else begin
                    size_push      = can_push;
                    push_word.data = size_word(size_q);
                end
            end
            ST_STREAM: begin
                data_push      = inflight_q;
                push_word.data = data_rd_data;
                issue          = !reads_done && ((occ_after + {1'b0, inflight_q}) < 2'd2);
            end
            ST_TRAILER: begin
                trl_push       = !trl_pushed_q && can_push;
                push_word.last = 1'b1;
                push_word.data = trl_word(8'(rd_ptr) + 8'd1);
            end
            default: ;
        endcase
    end

    // Event pointer, data pointer, captured size and per-event progress flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            data_addr_q  <= DATA_AW'(1);
            size_q       <= '0;
            issued_q     <= '0;
            hdr_pushed_q <= 1'b0;
            trl_pushed_q <= 1'b0;
            inflight_q   <= 1'b0;
            evt_sent     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                data_addr_q <= data_addr_q + DATA_AW'(1);
                issued_q    <= issued_q + ES_W'(1);
            end
            if (hdr_push) begin
                size_q       <= es_rd_data;
                issued_q     <= '0;
                hdr_pushed_q <= 1'b1;
            end
            if (size_push) begin
                hdr_pushed_q <= 1'b0;
            end
            if (trl_push) begin
                trl_pushed_q <= 1'b1;
            end
            if (trl_done) begin
                trl_pushed_q <= 1'b0;
                rd_ptr       <= rd_ptr + EVT_AW'(1);
                evt_sent     <= evt_sent + EVT_AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Bench for mem_read_scheduler: RAM models, a packet-level reference model
// feeding a scoreboard, and directed plus randomized event sequences.
module tb_mem_read_scheduler;

    localparam int DATA_AW = 16;
    localparam int EVT_AW  = 8;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [EVT_AW-1:0]  es_wr_addr;
    logic [EVT_AW-1:0]  es_rd_addr;
    logic [10:0]        es_rd_data;
    logic [EVT_AW-1:0]  L1A_rd_addr;
    logic [13:0]        L1A_rd_data;
    logic [DATA_AW-1:0] data_rd_addr;
    logic [15:0]        data_rd_data;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic [EVT_AW-1:0]  evt_sent;

    logic [15:0] data_mem [0:65535];
    logic [10:0] es_mem   [0:255];
    logic [13:0] l1a_mem  [0:255];

    exp_t        sb [$];
    logic [7:0]  m_rd_ptr;
    logic [15:0] m_dptr;
    logic [7:0]  m_sent;

    int          n_checks;
    int          n_errors;
    int          n_beats;
    int          n_pkts;
    logic [15:0] last_trl;
    logic        ready_rand;
    logic        ready_level;

    mem_read_scheduler #(.DATA_AW(DATA_AW), .EVT_AW(EVT_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .es_wr_addr   (es_wr_addr),
        .es_rd_addr   (es_rd_addr),
        .es_rd_data   (es_rd_data),
        .L1A_rd_addr  (L1A_rd_addr),
        .L1A_rd_data  (L1A_rd_data),
        .data_rd_addr (data_rd_addr),
        .data_rd_data (data_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .evt_sent     (evt_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAMs with one cycle of latency.
    always @(posedge clk) begin
        es_rd_data   <= es_mem[es_rd_addr];
        L1A_rd_data  <= l1a_mem[L1A_rd_addr];
        data_rd_data <= data_mem[data_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one event becomes header, size, payload words, trailer.
    task automatic model_event();
        logic [7:0] a;
        exp_t       e;
        a = m_rd_ptr + 8'd1;
        e.last = 1'b0;
        e.data = 16'h8000 | 16'(l1a_mem[a]);
        sb.push_back(e);
        e.data = 16'(es_mem[a]);
        sb.push_back(e);
        for (int i = 0; i < int'(es_mem[a]); i++) begin
            m_dptr = m_dptr + 16'd1;
            e.data = data_mem[m_dptr];
            sb.push_back(e);
        end
        e.last = 1'b1;
        e.data = 16'hF000 | 16'(a);
        sb.push_back(e);
        m_rd_ptr = a;
        m_sent   = m_sent + 8'd1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drained"}, 32'(sb.size()), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sink: random or fixed ready, changed just after the active edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_level;
        end
    end

    // Monitor: every presented word must match the scoreboard head, stalled or not.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("word_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_last", 32'(out_last), 32'(sb[0].last));
                if (out_ready) begin
                    if (sb[0].last) begin
                        last_trl = out_data;
                        n_pkts++;
                    end
                    void'(sb.pop_front());
                    n_beats++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d words outstanding", sb.size());
        $fatal(1);
    end

    initial begin
        int base;
        int lat;
        int seen;
        int k;
        int t;
        logic [7:0] a;

        n_checks = 0; n_errors = 0; n_beats = 0; n_pkts = 0; last_trl = '0;
        m_rd_ptr = '0; m_dptr = '0; m_sent = '0;
        ready_rand = 1'b0; ready_level = 1'b1;
        reset = 1'b0; enable = 1'b1; es_wr_addr = '0;
        for (int i = 0; i < 65536; i++) data_mem[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) begin
            es_mem[i]  = 11'($urandom_range(0, 3));
            l1a_mem[i] = 14'($urandom);
        end

        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_evt_sent", 32'(evt_sent), 0);
        check("rst_es_addr", 32'(es_rd_addr), 1);
        check("rst_l1a_addr", 32'(L1A_rd_addr), 1);
        check("rst_data_addr", 32'(data_rd_addr), 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) step();

        // Basic 4-word event with latency measurement.
        es_mem[1] = 11'd4;
        l1a_mem[1] = 14'h0123;
        for (int i = 1; i <= 4; i++) data_mem[i] = 16'hA000 + 16'(i);
        step();
        es_wr_addr = 8'd1;
        model_event();
        base = n_beats;
        lat = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = j;
                break;
            end
        end
        check("hdr_latency", 32'(lat), 3);
        wait_drain("t1", 100);
        check("t1_beats", 32'(n_beats - base), 7);
        check("t1_trailer", 32'(last_trl), 32'h0000_F001);
        check("t1_evt_sent", 32'(evt_sent), 32'(m_sent));
        check("t1_data_addr", 32'(data_rd_addr), 32'(m_dptr + 16'd1));
        check("t1_es_addr", 32'(es_rd_addr), 32'(m_rd_ptr + 8'd1));

        // Empty event: three words, data pointer untouched.
        es_mem[2] = 11'd0;
        step();
        es_wr_addr = 8'd2;
        model_event();
        base = n_beats;
        wait_drain("t2", 100);
        check("t2_beats", 32'(n_beats - base), 3);
        check("t2_data_addr", 32'(data_rd_addr), 5);

        // 20-word event under random backpressure.
        es_mem[3] = 11'd20;
        ready_rand = 1'b1;
        step();
        es_wr_addr = 8'd3;
        model_event();
        base = n_beats;
        wait_drain("t3", 400);
        check("t3_beats", 32'(n_beats - base), 23);

        // Readout disabled with three events pending, then released.
        enable = 1'b0;
        for (int i = 4; i <= 6; i++) es_mem[i] = 11'($urandom_range(1, 6));
        step();
        es_wr_addr = 8'd6;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("disabled_quiet", 32'(seen), 0);
        base = n_pkts;
        step();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) model_event();
        wait_drain("t4", 600);
        check("t4_packets", 32'(n_pkts - base), 3);
        check("t4_evt_sent", 32'(evt_sent), 32'(m_sent));

        // Random groups of events with random sizes.
        for (int r = 0; r < 4; r++) begin
            k = int'($urandom_range(1, 3));
            for (int i = 1; i <= k; i++) begin
                a = es_wr_addr + 8'(i);
                es_mem[a] = 11'($urandom_range(0, 12));
            end
            step();
            es_wr_addr = es_wr_addr + 8'(k);
            for (int i = 0; i < k; i++) model_event();
            wait_drain("t5", 1000);
            check("t5_evt_sent", 32'(evt_sent), 32'(m_sent));
        end

        // Run the event pointer up to 255, then wrap to address 0.
        ready_rand = 1'b0;
        step();
        es_wr_addr = 8'd255;
        while (m_rd_ptr != 8'd255) model_event();
        wait_drain("t6_fill", 8000);
        check("pre_wrap_es_addr", 32'(es_rd_addr), 0);
        check("pre_wrap_evt_sent", 32'(evt_sent), 32'(m_sent));
        es_mem[0] = 11'($urandom_range(1, 4));
        step();
        es_wr_addr = 8'd0;
        model_event();
        wait_drain("t6_wrap", 200);
        check("wrap_trailer", 32'(last_trl), 32'h0000_F000);
        check("wrap_evt_sent", 32'(evt_sent), 32'(m_sent));
        check("wrap_es_addr", 32'(es_rd_addr), 1);

        // Reset in the middle of a long payload.
        es_mem[1] = 11'd30;
        ready_rand = 1'b1;
        step();
        es_wr_addr = 8'd1;
        model_event();
        base = n_beats;
        t = 0;
        while ((n_beats - base) < 6 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_progress", 32'((n_beats - base) >= 6), 1);
        check("busy_mid_stream", 32'(busy), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_evt_sent", 32'(evt_sent), 0);
        check("mid_rst_es_addr", 32'(es_rd_addr), 1);
        check("mid_rst_data_addr", 32'(data_rd_addr), 1);
        m_rd_ptr = '0; m_dptr = '0; m_sent = '0;
        es_mem[1] = 11'd5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_event();
        wait_drain("t7", 300);
        check("post_rst_evt_sent", 32'(evt_sent), 1);
        check("post_rst_data_addr", 32'(data_rd_addr), 6);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_read_scheduler.md
# mem_read_scheduler

Readout sequencer for the per-ADC event buffers written by the SFP front-end write control. It watches the event-size write pointer and, for each complete event, reads the L1A and event-size memories and then the event's words from the data memory. Each event goes out on a valid/ready stream as a framed packet: header, size, payload, trailer. It sits between the three dual-port RAMs (data, es, L1A) and the link/DAQ packer.

## Interface
- `DATA_AW`, 16: data memory address width.
- `EVT_AW`, 8: es/L1A memory address width.
- `clk`  in  1  single clock, all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  readout enable; sampled only in IDLE.
- `es_wr_addr`  in  EVT_AW  write-side event pointer; last written es/L1A address.
- `es_rd_addr`  out  EVT_AW  es memory read address.
- `es_rd_data`  in  11  event size in words; valid 1 cycle after address.
- `L1A_rd_addr`  out  EVT_AW  L1A memory read address; always equals `es_rd_addr`.
- `L1A_rd_data`  in  14  event L1A number; 1-cycle latency.
- `data_rd_addr`  out  DATA_AW  data memory read address.
- `data_rd_data`  in  16  payload word; 1-cycle latency.
- `out_data`  out  16  stream word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts when valid & ready.
- `out_last`  out  1  marks the trailer word.
- `busy`  out  1  FSM not in IDLE.
- `evt_sent`  out  EVT_AW  count of events fully sent, mod 2^EVT_AW.

## Operation
- Write side pre-increments its addresses, so the first event sits at address 1.
- Read pointers start at 0:
  - `es_rd_addr` = `rd_ptr` + 1.
  - `data_rd_addr` = `data_ptr` + 1, registered.
- Event available when `es_wr_addr` != `rd_ptr`, compared mod 2^EVT_AW. Both pointers wrap 255→0; `data_ptr` wraps mod 2^DATA_AW.
- FSM states:
  - **IDLE**: go to HDR_RD if `enable` and an event is available.
  - **HDR_RD**: one cycle while the RAMs return data; go to HDR_CAP.
  - **HDR_CAP**:
    - Latch `size`=`es_rd_data` and `l1a`=`L1A_rd_data`.
    - Push header {2'b10, l1a} and size word {5'b0, size} into the output FIFO (one per cycle as space allows).
    - Go to STREAM if `size`>0, else TRAILER.
  - **STREAM**:
    - Issue one data read per cycle while FIFO occupancy + in-flight reads < 2.
    - Returned word is pushed as-is; `data_ptr` increments per issued read.
    - After `size` reads issued and all returned, go to TRAILER.
  - **TRAILER**:
    - Push {8'hF0, `rd_ptr`[7:0]+1} with `out_last`=1.
    - When accepted: `rd_ptr`++, `evt_sent`++, go to IDLE.
- `size`=0 produces a 3-word packet: header, size, trailer.
- `enable` dropping mid-event has no effect until the trailer is accepted.
- No word is ever dropped or duplicated under backpressure; `out_data` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `evt_sent`=0.
  - `rd_ptr`=0, so `es_rd_addr`=`L1A_rd_addr`=1.
  - `data_ptr`=0, so `data_rd_addr`=1.
  - FIFO empty, FSM in IDLE.
- Reset mid-packet aborts immediately to these values; a partial packet is not completed.
- Latency: IDLE sampling an available event at cycle N → header `out_valid` at N+3, given an empty FIFO.
- Throughput with `out_ready` held high: 1 word/cycle in STREAM. Packet of `size` words occupies `size`+3 output beats.
- At least one IDLE cycle between packets.
- `es_wr_addr` changes in the same cycle as the IDLE compare: the new value is used next cycle only.
- `evt_sent` updates the cycle after trailer acceptance.

## Structure
- Shared package `ofc_readout_pkg`:
  - Header tag 2'b10 and trailer tag 8'hF0.
  - FSM state enum, es width 11, L1A width 14.
- Sub-module `out_skid_fifo`: 2-deep, 16+1 bits wide, count output used for read-issue throttling.

## Test plan
- `es_wr_addr` 0→1; es[1]=4, L1A[1]=0x0123; data[1..4]=0xA001..0xA004; `out_ready`=1 → stream 0x8123, 0x0004, 0xA001..0xA004, 0xF001 with `out_last`; first valid 3 cycles after event visible.
- es[1]=0 → exactly 3 words: header, 0x0000, trailer; `data_rd_addr` unchanged.
- Random `out_ready` (50%) on a 20-word event → all 23 words in order, none lost or duplicated; data held stable while stalled.
- `rd_ptr`=255, `es_wr_addr` 255→0 → event read from address 0; trailer low byte 0x00; `evt_sent` increments.
- Reset asserted mid-STREAM → `out_valid`=0 asynchronously; pointers return to 0; next packet starts at address 1.
- `enable`=0 with 3 events pending → no output; raise `enable` → three back-to-back packets, `evt_sent`=3.
